spi_slave_tx: RTL
=================

Name: spi_slave_tx

Overview:
SPI mode-0 responder that drives MISO back toward the SPI master. It also captures MOSI, so the master side gains a full-duplex peer. Sits on the system clock domain and oversamples the master's sclk/cs/mosi, so no sclk-domain flops exist. A local holding register lets the host queue the next transmit word while the current frame shifts out.

Parameters:
DATA_W, 12, frame length in bits; matches the master word size.
LSB_FIRST, 1, 1 = bit 0 first on the wire (master convention); 0 = MSB first.

Ports:
clk  input  1  system clock; all state on posedge clk
rst  input  1  asynchronous, active-low reset (asserted when 0)
sclk  input  1  serial clock from master, asynchronous to clk
cs  input  1  chip select from master, active-low, asynchronous
mosi  input  1  master-out data, asynchronous
miso  output  1  slave-out data (registered)
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; transfer on tx_valid && tx_ready
rx_data  output  DATA_W  last complete received word
rx_done  output  1  one-cycle pulse when rx_data updates
busy  output  1  high while a frame is in progress
underrun  output  1  one-cycle pulse: frame started with holding register empty
frame_err  output  1  one-cycle pulse: cs deasserted before DATA_W bits

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_done=0, busy=0, underrun=0, frame_err=0, state=IDLE, holding empty.
- Input conditioning: sclk, cs and mosi each pass through a 2-FF synchronizer. Edge detect compares the synchronized value with its 1-cycle delay.
- Edge events are seen 3 clk after the pin transition. Requirement: sclk high and low phases each >= 4 clk; mosi stable >= 3 clk around the sclk rise.
- Holding register: written on tx_valid && tx_ready. tx_ready drops the next cycle and returns to 1 the cycle after the holding word is loaded into the shifter.
- FSM states: IDLE, SHIFT, WAIT_CS.
- IDLE -> SHIFT on cs falling event:
  - If holding is full, its word loads the tx shifter and holding is cleared.
  - If holding is empty, zeros load the shifter and underrun pulses.
  - First bit goes to miso in the same cycle; busy=1; bit_cnt=0.
- SHIFT, sclk rising event: sample synchronized mosi into the rx shifter and increment bit_cnt. When bit_cnt reaches DATA_W:
  - rx_data <= assembled word.
  - rx_done pulses 1 cycle later.
  - Go to WAIT_CS.
- SHIFT, sclk falling event (not the final bit): advance the tx shifter; miso updates the same cycle.
- WAIT_CS: extra sclk edges are ignored and miso=0. On cs rising event -> IDLE, busy=0.
- SHIFT + cs rising event: abort. No rx_done, rx_data unchanged, frame_err pulses, state -> IDLE. The partially sent tx word is discarded, not requeued.
- miso = 0 whenever state is IDLE. It is not tri-stated.
- Bit order: LSB_FIRST=1 shifts right, so bit 0 is first on both miso and mosi. LSB_FIRST=0 mirrors this.
- Simultaneous tx_valid && tx_ready with a cs-fall event: the shifter loads from the pre-cycle holding state, so underrun fires if holding was empty. The new word lands in holding for the next frame.
- A cs-fall event while in WAIT_CS or SHIFT is impossible without a preceding rise; if it occurs it is ignored.
- Reset assertion mid-frame forces all reset values immediately, independent of clk.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_DATA_W = 12
  - typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} spi_slv_state_t
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated three times (sclk, cs, mosi; only the level output is used for mosi).

Test Plan:
1. Reset release, then write tx_data=12'hA5C, then master sends 12'h3F1 -> miso bit sequence is 0,0,1,1,1,0,1,0,0,1,0,1 (LSB first); rx_data=12'h3F1; rx_done is one pulse; tx_ready returns to 1 after the cs fall.
2. No tx write before frame; master sends 12'h000 -> underrun pulse at cs fall; miso held 0 for all 12 bits; rx_done still pulses.
3. Back-to-back frames: write 12'h111, then write 12'h222 during frame 1 -> frame 1 returns 12'h111 and frame 2 returns 12'h222; tx_ready=0 between the second write and the second cs fall.
4. Abort: cs rises after 5 sclk rises -> frame_err pulse; no rx_done; rx_data keeps its prior value; busy=0 within 4 clk of the cs rise.
5. Overclock: 14 sclk pulses in one frame with tx 12'hFFF -> rx_data is the first 12 mosi bits; miso=0 for pulses 13-14; single rx_done.
6. rst pulled low mid-frame (bit 6) -> all outputs return to reset values asynchronously; the next full frame after release completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

  localparam int SPI_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with one-cycle rise/fall pulses
// derived from the synchronized level and its one-cycle delay.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;
  assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 responder: oversamples sclk/cs/mosi on clk, shifts a queued word out
// on miso and assembles the incoming mosi word, with underrun/abort reporting.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DATA_W    = SPI_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              busy,
  output logic              underrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din_i(sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // cs idles high, so its synchronizer resets high to avoid a false frame start.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din_i(cs),
    .level_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
    return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  spi_slv_state_t    state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_upd_q, rx_upd_d;
  logic              rx_done_q;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] rx_next;

  assign rx_next = rx_insert(rx_sh_q, mosi_s);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_upd_d    = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    // Host writes only into an empty holding register, so this never collides
    // with the frame-start load below, which requires a full one.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          rx_sh_d   = '0;
          if (hold_full_q) begin
            tx_sh_d     = hold_q;
            hold_full_d = 1'b0;
            miso_d      = first_bit(hold_q);
          end else begin
            tx_sh_d    = '0;
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          rx_sh_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d = rx_next;
            rx_upd_d  = 1'b1;
            state_d   = WAIT_CS;
            miso_d    = 1'b0;
          end
        end else if (sclk_fall) begin
          tx_sh_d = tx_advance(tx_sh_q);
          miso_d  = first_bit(tx_advance(tx_sh_q));
        end
      end
      WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_upd_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_upd_q    <= rx_upd_d;
      rx_done_q   <= rx_upd_q;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Pure data registers: their contents only matter once a valid flag or state qualifies them.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign miso      = miso_q;
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule
